uart_tx_arb: RTL
================

Name: uart_tx_arb

Overview:
- Shares one UART transmitter AXI-Stream byte input among PORTS independent byte-stream requesters.
- Arbitration is round-robin at packet granularity: a grant is held until the requester's tlast beat or a burst-length cap.
- Sits between the requesting sources and the s_axis_* input of the top-level UART; output ports connect directly to that input.
- Reports the current owner for status/debug.

Parameters:
- PORTS, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of grant_id; must satisfy 2**ID_WIDTH >= PORTS.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- s_axis_tdata  input  PORTS*8  requester bytes; port i occupies bits [8*i+7:8*i].
- s_axis_tvalid  input  PORTS  per-requester valid.
- s_axis_tlast  input  PORTS  per-requester end-of-packet.
- s_axis_tready  output  PORTS  per-requester ready.
- m_axis_tdata  output  8  byte to the UART transmitter.
- m_axis_tvalid  output  1  valid to the UART transmitter.
- m_axis_tready  input  1  ready from the UART transmitter.
- max_burst  input  8  maximum beats per grant; 0 = unlimited. Sampled at grant time.
- grant_valid  output  1  a requester currently owns the output.
- grant_id  output  ID_WIDTH  index of the owning requester.
- burst_cut  output  1  one-cycle pulse when a grant is released by the max_burst cap instead of tlast.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, last_grant=PORTS-1, beat_cnt=0, burst_lim=0.
  - grant_valid=0, grant_id=0, burst_cut=0, m_axis_tvalid=0, s_axis_tready=0.
  - Reset mid-packet abandons the packet silently; no beat transfers in the reset cycle.
- Transfer definition: a beat transfers when m_axis_tvalid && m_axis_tready.
- State IDLE:
  - All s_axis_tready=0; m_axis_tvalid=0.
  - If any s_axis_tvalid=1, select the first asserted index scanning last_grant+1, last_grant+2, ... (mod PORTS).
  - Register grant_id, set grant_valid=1, latch burst_lim=max_burst, beat_cnt=0, go to XFER.
- State XFER (g = grant_id):
  - Output mux is combinational from the registered grant:
    - m_axis_tdata = s_axis_tdata[g].
    - m_axis_tvalid = s_axis_tvalid[g].
    - s_axis_tready[g] = m_axis_tready; all other readies = 0.
  - On each transfer, beat_cnt increments (8-bit, saturating at 255).
  - Release on a transfer with s_axis_tlast[g]=1: go to IDLE, last_grant=g, grant_valid=0.
  - Else release on a transfer where burst_lim!=0 and beat_cnt+1==burst_lim: go to IDLE, last_grant=g, burst_cut=1 for one cycle.
  - When both release conditions hold on the same transfer, it counts as a tlast release; burst_cut=0.
  - The owner dropping tvalid mid-packet does not release the grant; the arbiter waits indefinitely.
- Latency and bubbles:
  - First beat can transfer the cycle after the request is seen in IDLE (1-cycle arbitration bubble).
  - Between packets there is exactly one IDLE cycle.
  - Back-to-back beats within a packet run at full rate.
- Changing max_burst mid-grant has no effect until the next grant.
- PORTS=1: degenerates to a pass-through with a 1-cycle bubble per packet.
- No combinational path from m_axis_tready to any s_axis_tvalid-dependent decision other than the tready mux.

Decomposition:
- Shared package uart_pkg:
  - localparam UART_DATA_W=8.
  - Typedef arb_state_t {IDLE, XFER}.
  - Constant BURST_UNLIMITED=8'd0.
- One natural sub-module: rr_pick. Purely combinational; inputs req[PORTS] and last[ID_WIDTH]; outputs pick_id and pick_valid. Reusable by the matching RX-side demux.

Test Plan:
- Single requester: port 2 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43), m_axis_tready=1 → grant_id=2 one cycle after tvalid; bytes appear on consecutive cycles; grant_valid drops after the 0x43 transfer.
- Round-robin fairness: ports 0 and 1 continuously offer 2-byte packets → output alternates 0,1,0,1; exactly one idle cycle between packets; no interleaving within a packet.
- Backpressure: port 0 sends a 4-byte packet while m_axis_tready toggles 1,0,0,1,1,0,1 → no byte lost or duplicated; s_axis_tready[0] mirrors m_axis_tready; other readies stay 0.
- Burst cap: max_burst=2, port 3 sends a 5-byte packet while port 0 waits → port 3 sends 2 bytes with burst_cut pulsing once, then port 0 is granted, then port 3 resumes.
- Cap coincides with tlast: max_burst=3, port 1 sends a 3-byte packet → release with burst_cut=0.
- Reset mid-packet: assert rst after the 2nd of 4 bytes → next cycle all outputs are at reset values; after rst deasserts, port 0 is granted first if requesting.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side types and constants for the TX arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // A max_burst of zero means a grant lasts until tlast.
    localparam logic [7:0] BURST_UNLIMITED = 8'd0;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin picker: first asserted request after 'last', wrapping modulo PORTS.
// Latency: purely combinational.
// Backpressure: none; caller decides when to act on the pick.
// Ports: req (per-requester request), last (previous winner),
//        pick_id (chosen index), pick_valid (any request present).
module rr_pick
    import uart_pkg::*;
#(
    parameter int PORTS    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [PORTS-1:0]    req,
    input  logic [ID_WIDTH-1:0] last,
    output logic [ID_WIDTH-1:0] pick_id,
    output logic                pick_valid
);

    logic [ID_WIDTH-1:0] idx;

    // Scan last+1, last+2, ... so the previous winner is considered last.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = ID_WIDTH'((int'(last) + k) % PORTS);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one UART TX byte stream among PORTS sources.
// Latency: one IDLE arbitration cycle per grant, then full-rate beats from the owner.
// Backpressure: owner's tready is m_axis_tready; non-owners see tready=0.
// Ports: clk/rst (sync, active-high); s_axis_* per-requester byte streams (port i at
//        tdata[8*i+7:8*i]); m_axis_* to the UART; max_burst cap (0 = unlimited, sampled
//        at grant); grant_valid/grant_id owner status; burst_cut pulse on cap release.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int PORTS    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORTS*UART_DATA_W-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]             s_axis_tvalid,
    input  logic [PORTS-1:0]             s_axis_tlast,
    output logic [PORTS-1:0]             s_axis_tready,
    output logic [UART_DATA_W-1:0]       m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    input  logic [7:0]                   max_burst,
    output logic                         grant_valid,
    output logic [ID_WIDTH-1:0]          grant_id,
    output logic                         burst_cut
);

    arb_state_t          state, state_nxt;
    logic [ID_WIDTH-1:0] grant_id_nxt;
    logic [ID_WIDTH-1:0] last_grant, last_grant_nxt;
    logic [7:0]          beat_cnt, beat_cnt_nxt;
    logic [7:0]          burst_lim, burst_lim_nxt;
    logic                burst_cut_nxt;

    logic [ID_WIDTH-1:0] pick_id;
    logic                pick_valid;
    logic [UART_DATA_W-1:0] lane [PORTS];
    logic                active;
    logic                xfer;
    logic                cap_hit;

    rr_pick #(
        .PORTS    (PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (s_axis_tvalid),
        .last       (last_grant),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            lane[i] = s_axis_tdata[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    // Gating with rst keeps a beat from completing in the reset cycle, so a
    // source never believes a byte was taken that the UART will not send.
    assign active      = (state == XFER) && !rst;
    assign grant_valid = active;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (active) begin
            m_axis_tdata            = lane[grant_id];
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            s_axis_tready[grant_id] = m_axis_tready;
        end
    end

    assign xfer    = m_axis_tvalid && m_axis_tready;
    // Nine-bit compare so beat_cnt=255 cannot wrap into a false match.
    assign cap_hit = (burst_lim != BURST_UNLIMITED) &&
                     (({1'b0, beat_cnt} + 9'd1) == {1'b0, burst_lim});

    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        burst_lim_nxt  = burst_lim;
        burst_cut_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt     = XFER;
                    grant_id_nxt  = pick_id;
                    burst_lim_nxt = max_burst;
                    beat_cnt_nxt  = 8'd0;
                end
            end
            XFER: begin
                if (xfer) begin
                    beat_cnt_nxt = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
                    // tlast wins when it lands on the cap beat: no cut reported.
                    if (s_axis_tlast[grant_id]) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant_id;
                    end else if (cap_hit) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant_id;
                        burst_cut_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(PORTS - 1);
            beat_cnt   <= 8'd0;
            burst_lim  <= 8'd0;
            burst_cut  <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_id_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            burst_lim  <= burst_lim_nxt;
            burst_cut  <= burst_cut_nxt;
        end
    end

endmodule
